// File: rtl/branch_pkg.sv
// Shared opcode, state and width definitions for the execute-stage branch resolver.
// Optional statistics counters in branch_resolve are enabled by BRANCH_STATS_EN.
package branch_pkg;

  localparam int PC_WIDTH = 32;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic logic is_ctrl_flow(input logic [4:0] op);
    return (op == OP_J) || (op == OP_BNE) || (op == OP_JAL) ||
           (op == OP_JR) || (op == OP_BLT) || (op == OP_BEX);
  endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Combinational redirect-target mux: PC-relative add for conditional branches,
// absolute field for j/jal/bex and register value for jr.
module branch_target_gen
  import branch_pkg::*;
#(
  parameter int PC_W = PC_WIDTH
) (
  input  logic [4:0]      opcode,
  input  logic [PC_W-1:0] pc_plus1,
  input  logic [16:0]     imm17,
  input  logic [26:0]     target27,
  input  logic [PC_W-1:0] rd_val,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] tgt_zext;

  assign imm_sext = {{(PC_W-17){imm17[16]}}, imm17};
  assign tgt_zext = {{(PC_W-27){1'b0}}, target27};

  // Relative adds wrap modulo 2^PC_W; no overflow is reported.
  always_comb begin
    target = tgt_zext;
    case (opcode)
      OP_BNE, OP_BLT: target = pc_plus1 + imm_sext;
      OP_JR:          target = rd_val;
      default:        target = tgt_zext;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: decides taken/not-taken, registers the redirect PC
// and holds flush for FLUSH_CYCLES unstalled cycles. BRANCH_STATS_EN adds counters.
//
// state    | meaning
// ST_IDLE  | evaluate execute-stage instruction on unstalled edges
// ST_FLUSH | squash F/D; counter counts remaining unstalled flush cycles
module branch_resolve
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = PC_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            stall,
  input  logic [4:0]      opcode,
  input  logic            lt,
  input  logic            eq,
  input  logic [PC_W-1:0] pc_plus1,
  input  logic [16:0]     imm17,
  input  logic [26:0]     target27,
  input  logic [PC_W-1:0] rd_val,
  input  logic            rstatus_nz,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
`endif
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            busy
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic            taken;
  logic [PC_W-1:0] target;
  logic            evaluate;

  branch_target_gen #(.PC_W(PC_W)) u_target (
    .opcode   (opcode),
    .pc_plus1 (pc_plus1),
    .imm17    (imm17),
    .target27 (target27),
    .rd_val   (rd_val),
    .target   (target)
  );

  // With lt and eq both set, eq decides bne and lt decides blt.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BNE:             taken = !eq;
      OP_BLT:             taken = lt;
      OP_J, OP_JAL, OP_JR: taken = 1'b1;
      OP_BEX:             taken = rstatus_nz;
      default:            taken = 1'b0;
    endcase
  end

  assign evaluate = (state == ST_IDLE) && ex_valid && !stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      redirect <= 1'b0;
      if (!stall) begin
        case (state)
          ST_IDLE: begin
            if (ex_valid && taken) begin
              redirect    <= 1'b1;
              redirect_pc <= target;
              flush       <= 1'b1;
              busy        <= 1'b1;
              cnt         <= CNT_LOAD;
              state       <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            if (cnt == '0) begin
              flush <= 1'b0;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (evaluate && is_ctrl_flow(opcode)) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (taken && stat_taken != '1) stat_taken <= stat_taken + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model (stats checked with BRANCH_STATS_EN).
module tb_branch_resolve;

  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset, ex_valid, stall, lt, eq, rstatus_nz;
  logic [4:0]  opcode;
  logic [31:0] pc_plus1, rd_val;
  logic [16:0] imm17;
  logic [26:0] target27;
  logic        redirect, flush, busy;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  // model state: pulse, held PC, unstalled flush cycles still owed, stats
  bit          m_redirect;
  logic [31:0] m_pc;
  int          m_left;
  logic [31:0] m_br, m_tk;

  branch_resolve #(.FLUSH_CYCLES(FC), .PC_W(32)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .stall(stall),
    .opcode(opcode), .lt(lt), .eq(eq), .pc_plus1(pc_plus1), .imm17(imm17),
    .target27(target27), .rd_val(rd_val), .rstatus_nz(rstatus_nz),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken),
`endif
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void decide(input logic [4:0] op, input bit l, input bit e,
                                 input logic [31:0] pc, input logic [16:0] imm,
                                 input logic [26:0] t27, input logic [31:0] rd,
                                 input bit rnz, output bit cf, output bit tk,
                                 output logic [31:0] tg);
    cf = 1; tk = 0; tg = 32'h0;
    case (op)
      5'b00010: begin tk = !e;  tg = pc + 32'($signed(imm)); end
      5'b00110: begin tk = l;   tg = pc + 32'($signed(imm)); end
      5'b00001, 5'b00011, 5'b10110: begin tk = (op == 5'b10110) ? rnz : 1'b1; tg = {5'b0, t27}; end
      5'b00100: begin tk = 1;   tg = rd; end
      default:  cf = 0;
    endcase
  endfunction

  always @(posedge clock) begin
    bit cf, tk;
    logic [31:0] tg;
    if (reset) begin
      m_redirect = 0; m_pc = 0; m_left = 0; m_br = 0; m_tk = 0;
    end else begin
      m_redirect = 0;
      if (!stall) begin
        if (m_left > 0) m_left--;
        else if (ex_valid) begin
          decide(opcode, lt, eq, pc_plus1, imm17, target27, rd_val, rstatus_nz, cf, tk, tg);
          if (cf && m_br != 32'hFFFFFFFF) m_br++;
          if (tk) begin
            m_redirect = 1; m_pc = tg; m_left = FC;
            if (m_tk != 32'hFFFFFFFF) m_tk++;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("redirect", {31'b0, redirect}, {31'b0, m_redirect});
      check("redirect_pc", redirect_pc, m_pc);
      check("flush", {31'b0, flush}, {31'b0, m_left > 0});
      check("busy", {31'b0, busy}, {31'b0, m_left > 0});
`ifdef BRANCH_STATS_EN
      check("stat_branches", stat_branches, m_br);
      check("stat_taken", stat_taken, m_tk);
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input bit l, input bit e, input logic [31:0] pc,
                       input logic [16:0] imm, input logic [26:0] t27, input logic [31:0] rd,
                       input bit rnz);
    opcode = op; lt = l; eq = e; pc_plus1 = pc; imm17 = imm; target27 = t27;
    rd_val = rd; rstatus_nz = rnz; ex_valid = 1;
    step();
    ex_valid = 0;
  endtask

  task automatic count_flush(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!flush) break;
      n++;
      step();
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      step();
    end
    check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n, nred;
    logic [4:0] ops [8] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100,
                            5'b00110, 5'b10110, 5'b00000, 5'b11111};
    reset = 1; ex_valid = 0; stall = 0; opcode = 0; lt = 0; eq = 0; rstatus_nz = 0;
    pc_plus1 = 0; rd_val = 0; imm17 = 0; target27 = 0;
    step(); step();
    cmp_en = 1;
    check("rst_redirect", {31'b0, redirect}, 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    reset = 0;
    step();

    issue(5'b00110, 1, 0, 32'h10, 17'h1FFFC, 0, 0, 0);
    check("blt_redirect", {31'b0, redirect}, 32'd1);
    check("blt_pc", redirect_pc, 32'h0000000C);
    count_flush(n);
    check("blt_flush_len", n, 2);

    issue(5'b00010, 0, 1, 32'h40, 17'h5, 0, 0, 0);
    check("bne_eq_redirect", {31'b0, redirect}, 32'd0);
    check("bne_eq_flush", {31'b0, flush}, 32'd0);
    issue(5'b00010, 0, 0, 32'hFFFFFFFF, 17'h2, 0, 0, 0);
    check("bne_wrap_pc", redirect_pc, 32'h00000001);
    wait_idle();

    issue(5'b00100, 0, 0, 0, 0, 0, 32'h1234, 0);
    check("jr_pc", redirect_pc, 32'h1234);
    n = 0; nred = 0;
    for (int k = 0; k < 20; k++) begin
      if (!flush) break;
      n++;
      nred += redirect;
      stall = (n <= 3);
      step();
    end
    stall = 0;
    check("jr_stall_flush_len", n, 5);
    check("jr_pulse_count", nred, 1);

    issue(5'b10110, 0, 0, 0, 0, 27'h0ABCDEF, 0, 0);
    check("bex_nt_redirect", {31'b0, redirect}, 32'd0);
    issue(5'b10110, 0, 0, 0, 0, 27'h0ABCDEF, 0, 1);
    check("bex_pc", redirect_pc, 32'h00ABCDEF);
    wait_idle();

    issue(5'b00001, 0, 0, 0, 0, 27'h100, 0, 0);
    opcode = 5'b00011; target27 = 27'h200; ex_valid = 1;
    nred = 0;
    for (int k = 0; k < 20; k++) begin
      if (!flush) break;
      nred += redirect;
      step();
    end
    ex_valid = 0;
    check("j_jal_pulse_count", nred, 1);
    check("j_jal_pc", redirect_pc, 32'h100);
    step();

    issue(5'b00001, 0, 0, 0, 0, 27'h300, 0, 0);
    reset = 1;
    step();
    reset = 0;
    check("rst_mid_redirect", {31'b0, redirect}, 32'd0);
    check("rst_mid_pc", redirect_pc, 32'd0);
    check("rst_mid_flush", {31'b0, flush}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);

    issue(5'b00110, 1, 0, 32'h20, 17'h1, 0, 0, 0); wait_idle();
    issue(5'b00010, 0, 1, 32'h20, 17'h1, 0, 0, 0); wait_idle();
    issue(5'b00011, 0, 0, 0, 0, 27'h44, 0, 0);     wait_idle();
    issue(5'b10110, 0, 0, 0, 0, 27'h55, 0, 0);     wait_idle();
    issue(5'b00100, 0, 0, 0, 0, 0, 32'h66, 0);     wait_idle();
    issue(5'b00000, 0, 0, 0, 0, 0, 0, 0);          wait_idle();
    issue(5'b11111, 0, 0, 0, 0, 0, 0, 0);          wait_idle();
`ifdef BRANCH_STATS_EN
    check("stat_branches_5", stat_branches, 32'd5);
    check("stat_taken_3", stat_taken, 32'd3);
`endif

    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(63) == 0);
      ex_valid   = $urandom_range(1);
      stall      = ($urandom_range(3) == 0);
      opcode     = ops[$urandom_range(7)];
      lt         = $urandom_range(1);
      eq         = $urandom_range(1);
      rstatus_nz = $urandom_range(1);
      pc_plus1   = $urandom;
      imm17      = 17'($urandom);
      target27   = 27'($urandom);
      rd_val     = $urandom;
      step();
    end
    reset = 0; ex_valid = 0; stall = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage control-flow resolver that sits directly downstream of the ALU's 32-bit signed comparator.
- Consumes the comparator's LT/EQ flags (operands $rd vs $rs), the opcode and target fields, and decides whether the instruction redirects fetch.
- Registers the redirect PC and holds a squash (flush) signal toward fetch/decode for a fixed number of cycles through a small state machine.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays high after a taken redirect (≥1).
- PC_W, 32, width of PC and target datapath.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage holds a real instruction.
- stall  in  1  pipeline freeze (multdiv busy); holds all state.
- opcode  in  5  ISA opcode of the execute-stage instruction.
- lt  in  1  comparator LT: signed $rd < $rs.
- eq  in  1  comparator EQ: $rd == $rs.
- pc_plus1  in  PC_W  PC+1 of the execute-stage instruction.
- imm17  in  17  signed branch offset.
- target27  in  27  jump target field, zero-extended.
- rd_val  in  PC_W  $rd value (jr target).
- rstatus_nz  in  1  $rstatus != 0 (bex condition).
- redirect  out  1  one-cycle pulse: fetch loads redirect_pc.
- redirect_pc  out  PC_W  registered new PC.
- flush  out  1  squash the F/D instructions.
- busy  out  1  high while in FLUSH.

Behaviour:
- States: IDLE, FLUSH. On reset: IDLE, redirect=0, redirect_pc=0, flush=0, busy=0, counter=0.
- Evaluation happens on a rising edge only when state==IDLE, ex_valid=1 and stall=0.
- Taken conditions (opcode in binary):
  - bne 00010: !eq.
  - blt 00110: lt (true only when $rd < $rs).
  - j 00001, jal 00011, jr 00100: always taken.
  - bex 10110: rstatus_nz.
  - Any other opcode: not taken.
- Target rules:
  - bne/blt: pc_plus1 + sign_extend(imm17), modulo 2^PC_W (wrap, no overflow flag).
  - j/jal/bex: zero_extend(target27).
  - jr: rd_val.
- Taken outcome:
  - The next edge sets redirect=1 and loads redirect_pc.
  - flush=1, busy=1, counter=FLUSH_CYCLES-1, state→FLUSH.
  - Redirect latency is exactly 1 cycle after the evaluating edge.
- Not-taken outcome: outputs stay 0; redirect_pc holds its last value.
- redirect is a strict 1-cycle pulse and is cleared on the following edge even if stall=1.
- FLUSH state:
  - Each non-stalled edge: if counter==0, then flush=0, busy=0, state→IDLE; else counter-1.
  - So flush is high for exactly FLUSH_CYCLES non-stalled cycles.
  - stall=1 freezes the counter and state; flush stays high.
  - ex_valid is ignored in FLUSH (the instruction is squashed); no second redirect can start.
- stall=1 in IDLE: no evaluation; outputs unchanged, redirect forced 0.
- reset beats everything, including mid-FLUSH; it returns to IDLE with all outputs 0 on that edge.
- lt and eq both high is illegal input: eq wins for bne (not taken) and lt wins for blt (taken). No assertion in RTL.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_taken[31:0].
  - stat_branches increments on every evaluating edge with a control-flow opcode.
  - stat_taken increments on every taken redirect.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; the core behaviour is identical.

Decomposition:
- Shared package branch_pkg:
  - Opcode constants OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_BEX.
  - State encoding ST_IDLE/ST_FLUSH.
  - PC width constant.
- One natural sub-module: branch_target_gen, a combinational target mux with the sign-extend adder.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- blt with lt=1, pc_plus1=0x10, imm17=0x1FFFC (-4) → one edge later redirect=1 and redirect_pc=0x0C; flush high for exactly 2 cycles, then IDLE.
- bne with eq=1 → no redirect and no flush. Then bne with eq=0, pc_plus1=0xFFFFFFFF, imm17=2 → redirect_pc=0x00000001 (wrap-around).
- jr with rd_val=0x1234 and stall raised for 3 cycles during FLUSH → redirect pulse lasts 1 cycle; flush stays high for 2 non-stalled cycles plus 3 stalled cycles (5 total).
- bex with rstatus_nz=0 → no redirect. bex with rstatus_nz=1, target27=0x0ABCDEF → redirect_pc=0x00ABCDEF.
- Taken j, then a second valid taken jal during FLUSH → second ignored; redirect asserted only once. Reset asserted in cycle 1 of FLUSH → all outputs 0 the next cycle, state IDLE.
- With BRANCH_STATS_EN: 5 branches, 3 taken, plus 2 non-branch opcodes → stat_branches=5, stat_taken=3.
